// File: rtl/shr_operand_skid.sv
// Two-entry registered skid buffer staging a/sh_amt pairs for the SHR shifter.
// Carries a precomputed overflow flag (sh_amt >= DATAWIDTH) with each entry.
module shr_operand_skid #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_a,
  input  logic [DATAWIDTH-1:0] in_sh_amt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_a,
  output logic [DATAWIDTH-1:0] out_sh_amt,
  output logic                 out_sh_ovf,
  output logic [1:0]           count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [DATAWIDTH-1:0] DW_VAL = DATAWIDTH'(DATAWIDTH);

  state_t                 state_q;
  state_t                 state_d;
  logic                   ready_en_q;
  logic [DATAWIDTH-1:0]   head_a_q;
  logic [DATAWIDTH-1:0]   head_amt_q;
  logic                   head_ovf_q;
  logic [DATAWIDTH-1:0]   skid_a_q;
  logic [DATAWIDTH-1:0]   skid_amt_q;
  logic                   skid_ovf_q;
  logic                   in_ovf;
  logic                   accept;
  logic                   pop;
  logic                   load_head;
  logic                   load_skid;
  logic                   head_from_skid;

  assign in_ovf     = (in_sh_amt >= DW_VAL);
  assign out_valid  = (state_q != EMPTY);
  assign in_ready   = ready_en_q & (state_q != FULL);
  assign count      = state_q;
  assign out_a      = head_a_q;
  assign out_sh_amt = head_amt_q;
  assign out_sh_ovf = head_ovf_q;
  assign accept     = in_valid & in_ready;
  assign pop        = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_head = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          accept && !pop: begin
            load_skid = 1'b1;
            state_d   = FULL;
          end
          pop && !accept: begin
            state_d = EMPTY;
          end
          accept && pop: begin
            load_head = 1'b1;
          end
          default: ;
        endcase
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen
        if (pop) begin
          head_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= EMPTY;
      ready_en_q <= 1'b0;
      head_a_q   <= '0;
      head_amt_q <= '0;
      head_ovf_q <= 1'b0;
      skid_a_q   <= '0;
      skid_amt_q <= '0;
      skid_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (load_head) begin
        head_a_q   <= in_a;
        head_amt_q <= in_sh_amt;
        head_ovf_q <= in_ovf;
      end else if (head_from_skid) begin
        head_a_q   <= skid_a_q;
        head_amt_q <= skid_amt_q;
        head_ovf_q <= skid_ovf_q;
      end
      if (load_skid) begin
        skid_a_q   <= in_a;
        skid_amt_q <= in_sh_amt;
        skid_ovf_q <= in_ovf;
      end
    end
  end

endmodule

// File: tb/tb_shr_operand_skid.sv
// Scoreboard bench for shr_operand_skid.
// Driver pushes expected pairs on accept; monitor pops on each output pop.
module tb_shr_operand_skid;

  logic        Clk;
  logic        Rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_sh_amt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_sh_amt;
  logic        out_sh_ovf;
  logic [1:0]  count;

  typedef struct {
    logic [63:0] a;
    logic [63:0] amt;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;
  int   max_c;

  shr_operand_skid #(.DATAWIDTH(64)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_sh_amt  (in_sh_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_sh_amt (out_sh_amt),
    .out_sh_ovf (out_sh_ovf),
    .count      (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (int'(count) > max_c) max_c = int'(count);
    if (Rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_pop", {63'd0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_a", out_a, e.a);
        chk("out_sh_amt", out_sh_amt, e.amt);
        chk("out_sh_ovf", {63'd0, out_sh_ovf}, {63'd0, e.ovf});
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] amt,
                      input logic ovf);
    exp_t e;
    bit   done;
    done      = 0;
    in_valid  = 1'b1;
    in_a      = a;
    in_sh_amt = amt;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge Clk);
      if (in_ready) begin
        e.a   = a;
        e.amt = amt;
        e.ovf = ovf;
        q.push_back(e);
        done  = 1;
      end
      @(posedge Clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    max_c     = 0;
    Rst       = 1'b0;
    in_valid  = 1'b1;
    in_a      = 64'h55;
    in_sh_amt = 64'd3;
    out_ready = 1'b1;

    @(posedge Clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_count", {62'd0, count}, 64'd0);
    end
    chk("rst_out_a", out_a, 64'd0);
    in_valid = 1'b0;
    #1 Rst = 1'b1;
    #1 chk("rel_in_ready_lo", {63'd0, in_ready}, 64'd0);
    @(negedge Clk);
    chk("rel_in_ready_hi", {63'd0, in_ready}, 64'd1);
    @(posedge Clk);
    #1;

    send(64'hF0, 64'd4, 1'b0);
    @(negedge Clk);
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    @(negedge Clk);
    chk("single_drain", {63'd0, out_valid}, 64'd0);
    @(posedge Clk);
    #1;

    max_c = 0;
    for (int i = 0; i < 8; i++) send(64'(i), 64'(i), 1'b0);
    repeat (3) @(posedge Clk);
    #1;
    chk("stream_max_count", 64'(max_c), 64'd1);
    chk("stream_drained", 64'(q.size()), 64'd0);

    out_ready = 1'b0;
    send(64'hA1, 64'd1, 1'b0);
    send(64'hA2, 64'd2, 1'b0);
    in_valid  = 1'b1;
    in_a      = 64'hA3;
    in_sh_amt = 64'd3;
    @(negedge Clk);
    chk("bp_count", {62'd0, count}, 64'd2);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_head", out_a, 64'hA1);
    @(negedge Clk);
    chk("bp_hold_count", {62'd0, count}, 64'd2);
    @(posedge Clk);
    #1;
    out_ready = 1'b1;
    send(64'hA3, 64'd3, 1'b0);
    repeat (4) @(posedge Clk);
    #1;
    chk("bp_drained", 64'(q.size()), 64'd0);

    send(64'hDEAD, 64'd63, 1'b0);
    send(64'hBEEF, 64'd64, 1'b1);
    send(64'h1234, 64'hFFFF_FFFF_0000_0000, 1'b1);
    send(64'h0, 64'd0, 1'b0);
    repeat (3) @(posedge Clk);
    #1;

    out_ready = 1'b0;
    send(64'hC1, 64'd5, 1'b0);
    send(64'hC2, 64'd6, 1'b0);
    @(negedge Clk);
    chk("mid_pre_count", {62'd0, count}, 64'd2);
    #1 Rst = 1'b0;
    #1;
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_count", {62'd0, count}, 64'd0);
    chk("mid_out_a", out_a, 64'd0);
    chk("mid_out_sh_amt", out_sh_amt, 64'd0);
    chk("mid_out_ovf", {63'd0, out_sh_ovf}, 64'd0);
    chk("mid_in_ready", {63'd0, in_ready}, 64'd0);
    q.delete();
    #1 Rst = 1'b1;
    out_ready = 1'b1;
    @(posedge Clk);
    #1;
    send(64'hE1, 64'd65, 1'b1);
    send(64'hE2, 64'd7, 1'b0);
    repeat (4) @(posedge Clk);
    #1;
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/shr_operand_skid.md
# shr_operand_skid

Two-entry registered skid buffer that stages shift operands in front of the combinational SHR shifter in the datapath. It accepts `a` / `sh_amt` pairs over a valid/ready handshake and presents them registered to the SHR inputs. It also precomputes a shift-overflow flag (`sh_amt >= DATAWIDTH`). It breaks the timing path from the upstream producer into the shifter and absorbs one cycle of downstream backpressure without losing data.

## Interface
- `DATAWIDTH`, default 64: width of operand `a`, of `sh_amt`, and of the staged copies.
- `Clk`  input  1  clock; all state changes on the rising edge.
- `Rst`  input  1  reset; asynchronous assert, active-low (0 = in reset).
- `in_valid`  input  1  upstream offers an operand pair.
- `in_ready`  output  1  block can accept a pair this cycle.
- `in_a`  input  DATAWIDTH  value to be shifted.
- `in_sh_amt`  input  DATAWIDTH  shift amount.
- `out_valid`  output  1  staged pair is present on the `out_*` ports.
- `out_ready`  input  1  downstream (SHR consumer) takes the pair this cycle.
- `out_a`  output  DATAWIDTH  staged value; drives SHR `a`.
- `out_sh_amt`  output  DATAWIDTH  staged amount; drives SHR `sh_amt`.
- `out_sh_ovf`  output  1  1 when the staged `sh_amt >= DATAWIDTH`, meaning the SHR result is all zeros.
- `count`  output  2  occupancy, 0..2.

## Operation
- Storage:
  - head register: `a`, `sh_amt`, `ovf`; drives the `out_*` ports.
  - skid register: same fields.
  - 2-bit occupancy state.
- Events:
  - accept = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
- Outputs derived from state only, never combinationally from `in_valid` or `out_ready`:
  - `out_valid = (count != 0)`.
  - `in_ready = ready_en & (count != 2)`.
  - `ready_en` is a flop: reset to 0, set to 1 on the first rising edge with `Rst` high, then stays 1.
- `ovf` is computed at capture as a full-width unsigned compare `in_sh_amt >= DATAWIDTH`, and is stored alongside the data.
- State EMPTY (count 0):
  - accept: load head, go to ONE.
  - otherwise: hold.
- State ONE (count 1):
  - accept & !pop: load skid, go to FULL.
  - pop & !accept: go to EMPTY.
  - accept & pop: load head with the new pair, stay in ONE.
  - neither: hold.
- State FULL (count 2):
  - accept cannot occur (`in_ready` = 0).
  - pop: head <= skid, go to ONE.
  - otherwise: hold.
- Ordering is strict FIFO; no pair is dropped or duplicated.
- Head contents are stable while `out_valid & !out_ready`.
- Register contents are don't-care when their entry is unoccupied, but must be driven by flops (no latches).

## Timing
- Reset (`Rst` low, asynchronous) values:
  - `count` = 0, `out_valid` = 0, `in_ready` = 0.
  - `out_a` = 0, `out_sh_amt` = 0, `out_sh_ovf` = 0; skid register = 0.
- After `Rst` rises:
  - `in_ready` = 0 until the first rising edge, then 1.
  - The first accept is possible on the second edge after release.
- Latency: a pair accepted at edge k is on `out_*` with `out_valid` = 1 immediately after edge k (1 cycle).
- Throughput: 1 pair per cycle sustained while `out_ready` = 1.
- Backpressure:
  - `out_ready` low for one cycle with a stream present moves the state to FULL.
  - `in_ready` drops after that edge; no pair is lost.
- Reset mid-operation: all entries are discarded immediately and outputs take their reset values asynchronously. Nothing in flight survives.

## Test plan
- Reset:
  - Hold `Rst` = 0 for 3 cycles with `in_valid` = 1 -> `in_ready` = 0, `out_valid` = 0, `count` = 0 throughout.
  - Release `Rst` -> `in_ready` = 1 after one edge.
- Single transfer: `a` = 0xF0, `sh_amt` = 4, `out_ready` = 1 -> next cycle `out_valid` = 1, `out_a` = 0xF0, `out_sh_amt` = 4, `out_sh_ovf` = 0; `out_valid` = 0 the cycle after.
- Stream: 8 back-to-back pairs (`a` = i, `sh_amt` = i), `out_ready` = 1 -> outputs appear in order on consecutive cycles; `count` never exceeds 1.
- Backpressure:
  - `out_ready` = 0 while sending pairs P1, P2, P3 -> `count` = 2, `in_ready` = 0, P3 held upstream, `out_a` = P1.
  - Raise `out_ready` -> P1, P2, P3 delivered in order.
- Overflow flag (`DATAWIDTH` = 64):
  - `sh_amt` = 63 -> `out_sh_ovf` = 0.
  - `sh_amt` = 64 -> 1.
  - `sh_amt` = 0xFFFF_FFFF_0000_0000 -> 1.
- Mid-operation reset: with `count` = 2, pulse `Rst` low between clock edges -> `out_valid`, `count`, and `out_*` go to 0 without a clock edge; the next pair sent after recovery is the first one output.
